// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        ERROR = 1'b1
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with clear, occupancy count and head peek
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_clear        drop all entries (wins over i_push)
//   i_push/_data   write one entry; accepted when not full or when popping
//   i_pop          retire the head entry (ignored when empty)
//   o_count        registered occupancy 0..DEPTH
//   o_head         oldest entry (undefined when o_count == 0)
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop frees the slot the push lands in, so push+pop at full is safe.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: fetch PC, ROM requests, instruction FIFO, redirect
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req, imem_addr            ROM request (combinational) and address (= fetch PC)
//   imem_rdata                     ROM word, valid the cycle after imem_req
//   redirect_valid, redirect_pc    taken branch/jump from execute
//   instr_valid, instr_ready       decode handshake on the FIFO head
//   instr, instr_pc                head instruction/PC (NOP / 0 when empty)
//   fetch_err                      sticky misaligned-redirect error
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             fetch_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_inflight_pc;
    logic             r_inflight;

    logic [CNT_W-1:0]   w_count;
    logic [2*WIDTH-1:0] w_head;
    logic [CNT_W:0]     w_occ;
    logic               w_run;
    logic               w_misalign;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;

    assign w_run      = (r_state == RUN);
    assign w_misalign = (redirect_pc[1:0] != 2'b00);

    // Occupancy counts the outstanding response so the FIFO can never
    // overflow; a pop this cycle is deliberately not credited.
    assign w_occ    = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
    assign imem_req = w_run & ~rst & ~redirect_valid & (w_occ < (CNT_W + 1)'(DEPTH));
    assign imem_addr = r_pc;

    // A redirect kills the response arriving in the same cycle (wrong path).
    assign w_push  = r_inflight & w_run & ~redirect_valid;
    assign w_clear = redirect_valid & w_run;

    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    assign instr       = instr_valid ? w_head[WIDTH-1:0]       : WIDTH'(NOP_INSTR);
    assign instr_pc    = instr_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
    assign fetch_err   = (r_state == ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (w_run && redirect_valid) begin
            r_inflight <= 1'b0;
            if (w_misalign) begin
                r_state <= ERROR;
            end else begin
                r_pc <= redirect_pc;
            end
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + WIDTH'(INSTR_BYTES);
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_push_data ({r_inflight_pc, imem_rdata}),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst            = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        instr_valid;
    logic        instr_ready    = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;

    logic        rst2           = 1'b1;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2    = 32'h0;
    logic        instr_valid2;
    logic        instr_ready2    = 1'b1;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        fetch_err2;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_err      (fetch_err)
    );

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst            (rst2),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .instr_valid    (instr_valid2),
        .instr_ready    (instr_ready2),
        .instr          (instr2),
        .instr_pc       (instr_pc2),
        .fetch_err      (fetch_err2)
    );

    // Synchronous ROM: word[i] = i.
    always @(posedge clk) begin
        imem_rdata  <= imem_addr  >> 2;
        imem_rdata2 <= imem_addr2 >> 2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle, apply this cycle's inputs, let combinational outputs settle.
    task automatic cyc_in(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, instr_valid, 1);
        check({tag, "_pc"},    instr_pc,    pc);
        check({tag, "_instr"}, instr,       ins);
    endtask

    initial begin
        // ---- reset stream ----
        repeat (3) cyc_in(1, 0, 0, 1);
        check("rst_req",   imem_req,    0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr,       32'h0000_0013);
        check("rst_pc",    instr_pc,    0);
        check("rst_err",   fetch_err,   0);

        cyc_in(0, 0, 0, 1);
        check("r1_req",   imem_req,    1);
        check("r1_addr",  imem_addr,   0);
        check("r1_valid", instr_valid, 0);
        cyc_in(0, 0, 0, 1);
        check("r2_valid", instr_valid, 0);
        check("r2_addr",  imem_addr,   4);
        for (int k = 0; k < 6; k++) begin
            cyc_in(0, 0, 0, 1);
            expect_head($sformatf("stream%0d", k), 32'(4 * k), 32'(k));
        end

        // ---- backpressure: head held, requests stop once FIFO is full ----
        for (int j = 0; j < 10; j++) begin
            cyc_in(0, 0, 0, 0);
            expect_head($sformatf("hold%0d", j), 32'd24, 32'd6);
            check($sformatf("hold%0d_req", j), imem_req, (j < 2) ? 1 : 0);
        end
        for (int j = 0; j < 8; j++) begin
            cyc_in(0, 0, 0, 1);
            expect_head($sformatf("drain%0d", j), 32'(24 + 4 * j), 32'(6 + j));
        end

        // ---- aligned redirect mid-stream ----
        cyc_in(0, 1, 32'h40, 1);
        check("rd_t_req", imem_req, 0);
        check("rd_t_pc",  instr_pc, 32'd56);
        cyc_in(0, 0, 0, 1);
        check("rd_t1_valid", instr_valid, 0);
        check("rd_t1_req",   imem_req,    1);
        check("rd_t1_addr",  imem_addr,   32'h40);
        cyc_in(0, 0, 0, 1);
        check("rd_t2_valid", instr_valid, 0);
        check("rd_t2_addr",  imem_addr,   32'h44);
        for (int k = 0; k < 3; k++) begin
            cyc_in(0, 0, 0, 1);
            expect_head($sformatf("rd_t%0d", 3 + k), 32'(32'h40 + 4 * k), 32'(32'h10 + k));
        end

        // ---- redirect with three queued entries and a response in flight ----
        cyc_in(0, 0, 0, 0);
        expect_head("fl_u0", 32'h4C, 32'h13);
        cyc_in(0, 0, 0, 0);
        expect_head("fl_u1", 32'h4C, 32'h13);
        cyc_in(0, 1, 32'h80, 1);
        check("fl_t_req", imem_req, 0);
        check("fl_t_pc",  instr_pc, 32'h4C);
        cyc_in(0, 0, 0, 1);
        check("fl_t1_valid", instr_valid, 0);
        check("fl_t1_addr",  imem_addr,   32'h80);
        cyc_in(0, 0, 0, 1);
        check("fl_t2_valid", instr_valid, 0);
        for (int k = 0; k < 3; k++) begin
            cyc_in(0, 0, 0, 1);
            expect_head($sformatf("fl_t%0d", 3 + k), 32'(32'h80 + 4 * k), 32'(32'h20 + k));
        end

        // ---- misaligned redirect ----
        cyc_in(0, 1, 32'h42, 1);
        check("mis_t_err", fetch_err, 0);
        check("mis_t_req", imem_req,  0);
        for (int i = 1; i <= 20; i++) begin
            cyc_in(0, 0, 0, 1);
            check($sformatf("mis%0d_err", i),   fetch_err,   1);
            check($sformatf("mis%0d_req", i),   imem_req,    0);
            check($sformatf("mis%0d_valid", i), instr_valid, 0);
        end
        cyc_in(1, 0, 0, 1);
        cyc_in(1, 0, 0, 1);
        check("mis_rst_err",   fetch_err,   0);
        check("mis_rst_valid", instr_valid, 0);
        check("mis_rst_req",   imem_req,    0);
        cyc_in(0, 0, 0, 1);
        check("mis_r1_req",  imem_req,  1);
        check("mis_r1_addr", imem_addr, 0);
        cyc_in(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc_in(0, 0, 0, 1);
            expect_head($sformatf("mis_r%0d", 3 + k), 32'(4 * k), 32'(k));
        end

        // ---- mid-run reset together with a redirect: reset wins ----
        cyc_in(1, 1, 32'h40, 1);
        check("mr_req", imem_req, 0);
        cyc_in(0, 0, 0, 1);
        check("mr1_valid", instr_valid, 0);
        check("mr1_req",   imem_req,    1);
        check("mr1_addr",  imem_addr,   0);
        cyc_in(0, 0, 0, 1);
        check("mr2_valid", instr_valid, 0);
        for (int k = 0; k < 2; k++) begin
            cyc_in(0, 0, 0, 1);
            expect_head($sformatf("mr%0d", 3 + k), 32'(4 * k), 32'(k));
        end

        // ---- PC wrap-around from RESET_PC = FFFFFFF8 ----
        cyc_in(0, 0, 0, 1);
        rst2 = 1'b0;
        #1;
        check("wr1_req",  imem_req2,  1);
        check("wr1_addr", imem_addr2, 32'hFFFF_FFF8);
        cyc_in(0, 0, 0, 1);
        check("wr2_addr",  imem_addr2,   32'hFFFF_FFFC);
        check("wr2_valid", instr_valid2, 0);
        cyc_in(0, 0, 0, 1);
        check("wr3_valid", instr_valid2, 1);
        check("wr3_pc",    instr_pc2,    32'hFFFF_FFF8);
        check("wr3_instr", instr2,       32'h3FFF_FFFE);
        check("wr3_addr",  imem_addr2,   32'h0);
        cyc_in(0, 0, 0, 1);
        check("wr4_pc",    instr_pc2,    32'hFFFF_FFFC);
        check("wr4_instr", instr2,       32'h3FFF_FFFF);
        cyc_in(0, 0, 0, 1);
        check("wr5_valid", instr_valid2, 1);
        check("wr5_pc",    instr_pc2,    32'h0);
        check("wr5_instr", instr2,       32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
